afe_serial_arbiter: RTL and testbench

Arbitrates the single AFE serial command port (the command-word interface of the serial shifter) between three requesters. The requesters are the boot-time configuration sequencer and two runtime requesters (host register-write path and periodic gain/trim update engine). Sits between the requesters and the serial shifter, and replaces the direct connection from the command controller to the shifter. Provides a per-transaction acknowledge, a transaction watchdog and a sticky timeout flag.

---
 rtl/afe_serial_arbiter.sv | 159 +++++++++++++++
 tb/tb_afe_serial_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_serial_arbiter.sv
// afe_serial_arbiter
// Shares the single AFE serial command port between the boot configuration
// sequencer (cfg, fixed highest priority) and two runtime requesters
// (rt0/rt1, round-robin, only once boot configuration is done). One command
// is in flight at a time. A watchdog abandons a transaction whose ser_done
// never arrives and records that in a sticky error flag.
//
// Ports
//   clk, reset_n             system clock, async active-low reset
//   enable                   arbitration allowed (new grants only)
//   cfg_done                 boot config complete; gates rt0/rt1 eligibility
//   cfg_req/cfg_cmd/cfg_ack  config requester (req+stable cmd, 1-cycle ack)
//   rt0_*, rt1_*             runtime requesters, same protocol
//   ser_start, ser_cmd       start pulse and registered command to shifter
//   ser_done                 shifter completion pulse (honoured in WAIT only)
//   busy                     high whenever not IDLE
//   grant                    owner: 00 none, 01 cfg, 10 rt0, 11 rt1
//   timeout_err              sticky watchdog error, cleared by reset only
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for enable and an eligible request
// ISSUE | ser_start pulse, watchdog cleared
// WAIT  | waiting for ser_done, watchdog counting
// ACK   | one-cycle ack to owner, round-robin pointer update
// GAP   | one dead cycle so the owner's trailing req is not resampled
module afe_serial_arbiter #(
    parameter int CMD_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 cfg_done,
    input  logic                 cfg_req,
    input  logic [CMD_WIDTH-1:0] cfg_cmd,
    output logic                 cfg_ack,
    input  logic                 rt0_req,
    input  logic [CMD_WIDTH-1:0] rt0_cmd,
    output logic                 rt0_ack,
    input  logic                 rt1_req,
    input  logic [CMD_WIDTH-1:0] rt1_cmd,
    output logic                 rt1_ack,
    output logic                 ser_start,
    output logic [CMD_WIDTH-1:0] ser_cmd,
    input  logic                 ser_done,
    output logic                 busy,
    output logic [1:0]           grant,
    output logic                 timeout_err
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_CFG  = 2'b01;
    localparam logic [1:0] G_RT0  = 2'b10;
    localparam logic [1:0] G_RT1  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state_q,   state_d;
    logic [1:0]             grant_q,   grant_d;
    logic [CMD_WIDTH-1:0]   ser_cmd_q, ser_cmd_d;
    logic                   rr_q,      rr_d;      // 0: rt0 favoured, 1: rt1 favoured
    logic [WD_W-1:0]        wd_q,      wd_d;
    logic                   timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            grant_q   <= G_NONE;
            ser_cmd_q <= '0;
            rr_q      <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ser_cmd_q <= ser_cmd_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ser_cmd_d = ser_cmd_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (cfg_req) begin
                        grant_d   = G_CFG;
                        ser_cmd_d = cfg_cmd;
                        state_d   = S_ISSUE;
                    end else if (cfg_done && (rt0_req || rt1_req)) begin
                        // rt0 wins when it is the only one asking or when it is favoured
                        if (rt0_req && (!rt1_req || !rr_q)) begin
                            grant_d   = G_RT0;
                            ser_cmd_d = rt0_cmd;
                        end else begin
                            grant_d   = G_RT1;
                            ser_cmd_d = rt1_cmd;
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (ser_done) begin
                    state_d = S_ACK;
                end else if (wd_q == WD_TC) begin
                    timeout_d = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (grant_q == G_RT0) rr_d = 1'b1;
                if (grant_q == G_RT1) rr_d = 1'b0;
                grant_d = G_NONE;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = G_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    assign ser_start   = (state_q == S_ISSUE);
    assign ser_cmd     = ser_cmd_q;
    assign busy        = (state_q != S_IDLE);
    assign grant       = grant_q;
    assign timeout_err = timeout_q;
    assign cfg_ack     = (state_q == S_ACK) && (grant_q == G_CFG);
    assign rt0_ack     = (state_q == S_ACK) && (grant_q == G_RT0);
    assign rt1_ack     = (state_q == S_ACK) && (grant_q == G_RT1);

endmodule

// File: tb/tb_afe_serial_arbiter.sv
// Directed bench for afe_serial_arbiter, watchdog shortened to 16 cycles.
module tb_afe_serial_arbiter;

    localparam int CW = 20;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_done = 1'b0;
    logic          cfg_req = 1'b0;
    logic [CW-1:0] cfg_cmd = '0;
    logic          cfg_ack;
    logic          rt0_req = 1'b0;
    logic [CW-1:0] rt0_cmd = '0;
    logic          rt0_ack;
    logic          rt1_req = 1'b0;
    logic [CW-1:0] rt1_cmd = '0;
    logic          rt1_ack;
    logic          ser_start;
    logic [CW-1:0] ser_cmd;
    logic          ser_done = 1'b0;
    logic          busy;
    logic [1:0]    grant;
    logic          timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    afe_serial_arbiter #(.CMD_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_done   (cfg_done),
        .cfg_req    (cfg_req),
        .cfg_cmd    (cfg_cmd),
        .cfg_ack    (cfg_ack),
        .rt0_req    (rt0_req),
        .rt0_cmd    (rt0_cmd),
        .rt0_ack    (rt0_ack),
        .rt1_req    (rt1_req),
        .rt1_cmd    (rt1_cmd),
        .rt1_ack    (rt1_ack),
        .ser_start  (ser_start),
        .ser_cmd    (ser_cmd),
        .ser_done   (ser_done),
        .busy       (busy),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Ticks until ser_start, bounded; n is the number of cycles it took.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ser_start && n < 100);
        chk({tag, " start"}, 32'(ser_start), 1);
    endtask

    // One full transaction: expect grant/cmd at ser_start, answer ser_done
    // after 'delay' cycles, expect the owner's ack the next cycle.
    task automatic run_txn(input string tag, input int exp_grant, input logic [31:0] exp_cmd,
                           input int delay, output int n);
        wait_start(tag, n);
        chk({tag, " grant"}, 32'(grant), 32'(exp_grant));
        chk({tag, " cmd"}, 32'(ser_cmd), exp_cmd);
        repeat (delay) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk({tag, " ack"}, 32'({rt1_ack, rt0_ack, cfg_ack}), 32'(1 << (exp_grant - 1)));
    endtask

    initial begin
        int n;
        int starts;

        cfg_cmd = 20'hA5A5A;
        rt0_cmd = 20'h12345;
        rt1_cmd = 20'h6789A;

        // Reset state
        repeat (2) tick();
        chk("rst outputs", 32'({ser_start, cfg_ack, rt0_ack, rt1_ack, busy, grant, timeout_err}), 0);
        chk("rst ser_cmd", 32'(ser_cmd), 0);
        reset_n = 1'b1;
        tick();

        // Single cfg write: start one cycle after the request is seen
        enable  = 1'b1;
        cfg_req = 1'b1;
        tick();
        chk("cfg start", 32'(ser_start), 1);
        chk("cfg cmd", 32'(ser_cmd), 32'hA5A5A);
        chk("cfg grant", 32'(grant), 1);
        tick();
        chk("cfg start pulse", 32'(ser_start), 0);
        repeat (9) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("cfg ack", 32'(cfg_ack), 1);
        cfg_req = 1'b0;
        tick();
        chk("gap ack low", 32'(cfg_ack), 0);
        chk("gap busy", 32'(busy), 1);
        chk("gap grant", 32'(grant), 0);
        tick();
        chk("idle busy", 32'(busy), 0);
        chk("cmd held", 32'(ser_cmd), 32'hA5A5A);

        // Eligibility gate
        cfg_done = 1'b0;
        rt0_req  = 1'b1;
        starts   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ser_start) starts++;
        end
        chk("gate no start", 32'(starts), 0);
        cfg_done = 1'b1;
        tick();
        chk("gate start", 32'(ser_start), 1);
        chk("gate grant", 32'(grant), 2);
        chk("gate cmd", 32'(ser_cmd), 32'h12345);
        repeat (2) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("gate ack", 32'(rt0_ack), 1);
        rt0_req = 1'b0;
        repeat (2) tick();

        // Priority and round-robin from a fresh pointer
        do_reset();
        cfg_req = 1'b1;
        rt0_req = 1'b1;
        rt1_req = 1'b1;
        run_txn("prio cfg1", 1, 32'hA5A5A, 3, n);
        run_txn("prio cfg2", 1, 32'hA5A5A, 2, n);
        chk("prio regrant latency", 32'(n), 3);
        run_txn("prio cfg3", 1, 32'hA5A5A, 1, n);
        cfg_req = 1'b0;
        run_txn("rr rt0 a", 2, 32'h12345, 2, n);
        run_txn("rr rt1 a", 3, 32'h6789A, 2, n);
        run_txn("rr rt0 b", 2, 32'h12345, 4, n);
        run_txn("rr rt1 b", 3, 32'h6789A, 1, n);
        rt0_req = 1'b0;
        rt1_req = 1'b0;
        repeat (2) tick();

        // Watchdog expiry: ack 17 cycles after ser_start, sticky error
        do_reset();
        cfg_req = 1'b1;
        wait_start("wd", n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cfg_ack && n < 40);
        chk("wd ack delay", 32'(n), 17);
        chk("wd err", 32'(timeout_err), 1);
        cfg_req = 1'b0;
        repeat (3) tick();
        chk("wd err sticky", 32'(timeout_err), 1);
        chk("wd idle", 32'(busy), 0);

        // ser_done on the terminal-count cycle wins
        do_reset();
        cfg_req = 1'b1;
        wait_start("wd tc", n);
        repeat (16) tick();
        chk("wd tc still waiting", 32'(cfg_ack), 0);
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("wd tc ack", 32'(cfg_ack), 1);
        chk("wd tc no err", 32'(timeout_err), 0);
        cfg_req = 1'b0;
        repeat (2) tick();

        // Enable drop mid-transaction
        rt0_req = 1'b1;
        wait_start("en", n);
        chk("en grant", 32'(grant), 2);
        tick();
        enable  = 1'b0;
        rt1_req = 1'b1;
        tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("en ack", 32'(rt0_ack), 1);
        rt0_req = 1'b0;
        starts  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ser_start) starts++;
        end
        chk("en stall", 32'(starts), 0);
        chk("en stall idle", 32'(busy), 0);
        enable = 1'b1;
        tick();
        chk("en resume start", 32'(ser_start), 1);
        chk("en resume grant", 32'(grant), 3);
        tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("en resume ack", 32'(rt1_ack), 1);
        rt1_req = 1'b0;
        repeat (2) tick();

        // Async reset while in WAIT, then re-grant of the pending cfg_req
        cfg_req = 1'b1;
        wait_start("ar", n);
        repeat (2) tick();
        chk("ar in wait", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("ar outputs", 32'({ser_start, cfg_ack, rt0_ack, rt1_ack, busy, grant, timeout_err}), 0);
        chk("ar ser_cmd", 32'(ser_cmd), 0);
        #1;
        reset_n = 1'b1;
        tick();
        chk("ar restart", 32'(ser_start), 1);
        chk("ar grant", 32'(grant), 1);
        chk("ar cmd", 32'(ser_cmd), 32'hA5A5A);
        tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("ar ack", 32'(cfg_ack), 1);
        cfg_req = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
